// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmit path and the later receive path:
//   - uart_state_t : frame sequencer states
//   - PARIDADE_*   : parity mode codes used by the PARITY parameter
//   - calc_clks_per_bit / calc_cnt_width : bit-time length in clocks and the
//     width of the counter that measures it
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        INICIO   = 3'd1,
        DADOS    = 3'd2,
        PARIDADE = 3'd3,
        PARADA   = 3'd4
    } uart_state_t;

    localparam int PARIDADE_NENHUMA = 0;
    localparam int PARIDADE_PAR     = 1;
    localparam int PARIDADE_IMPAR   = 2;

    // Integer division on purpose: the resulting baud error is accepted.
    function automatic int calc_clks_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    // Width needed to count 0 .. clks_per_bit-1.
    function automatic int calc_cnt_width(input int clks_per_bit);
        return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer_if
// Byte handshake between the payload senders and the UART transmitter.
//   iniciar_envio : sender -> uart, request to send dado_entrada
//   dado_entrada  : sender -> uart, byte to send (sampled on acceptance)
//   tx            : uart   -> line, serial output (idles high)
//   uart_ocupado  : uart   -> sender, frame in flight
//   byte_enviado  : uart   -> sender, one-cycle pulse at end of frame
// master = payload sender side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface uart_tx_serializer_if;
    logic       iniciar_envio;
    logic [7:0] dado_entrada;
    logic       tx;
    logic       uart_ocupado;
    logic       byte_enviado;

    modport master (
        output iniciar_envio,
        output dado_entrada,
        input  tx,
        input  uart_ocupado,
        input  byte_enviado
    );

    modport slave (
        input  iniciar_envio,
        input  dado_entrada,
        output tx,
        output uart_ocupado,
        output byte_enviado
    );
endinterface

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Bit-time counter. Counts 0 .. CLKS_PER_BIT-1 and flags the last count so
// the user can advance exactly on the wrap edge.
//   clock    : system clock
//   reset    : synchronous active-high reset
//   restart  : holds the counter at 0 (used while the line is idle so the
//              first bit of a frame gets a full bit time)
//   bit_tick : high during the last clock of each bit time
// ---------------------------------------------------------------------------
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic bit_tick
);
    localparam int                 CNT_W   = calc_cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clock) begin
        if (reset || restart) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_MAX) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign bit_tick = (cnt_reg == CNT_MAX) && !restart;

endmodule

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
// Byte-wide UART transmitter: start bit, 8 data bits LSB first, optional
// parity bit, 1 or 2 stop bits. One byte per accepted request.
//   clock : system clock, rising edge
//   reset : synchronous active-high reset (abandons any frame in flight)
//   bus   : uart_tx_serializer_if.slave (iniciar_envio, dado_entrada in;
//           tx, uart_ocupado, byte_enviado out, all registered)
// Parameters: CLOCK_FREQ, BAUD_RATE (bit time = CLOCK_FREQ/BAUD_RATE clocks),
// PARITY (0 none, 1 even, 2 odd), STOP_BITS (1 or 2).
// ---------------------------------------------------------------------------
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int PARITY     = PARIDADE_NENHUMA,
    parameter int STOP_BITS  = 1
) (
    input logic                 clock,
    input logic                 reset,
    uart_tx_serializer_if.slave bus
);
    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLOCK_FREQ, BAUD_RATE);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_serializer: CLOCK_FREQ/BAUD_RATE must be >= 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end

    uart_state_t state_reg;
    logic        tx_reg;
    logic        ocupado_reg;
    logic        enviado_reg;
    logic [2:0]  bit_idx_reg;
    logic [7:0]  shift_reg;
    logic        parity_reg;
    logic        stop_cnt_reg;
    logic        bit_tick;
    logic        baud_restart;

    // Counter is parked at 0 while idle, so the acceptance edge starts a
    // full start-bit time and back-to-back frames need no idle gap.
    assign baud_restart = (state_reg == OCIOSO);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clock   (clock),
        .reset   (reset),
        .restart (baud_restart),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= OCIOSO;
            tx_reg       <= 1'b1;
            ocupado_reg  <= 1'b0;
            enviado_reg  <= 1'b0;
            bit_idx_reg  <= 3'd0;
            shift_reg    <= 8'd0;
            parity_reg   <= 1'b0;
            stop_cnt_reg <= 1'b0;
        end else begin
            enviado_reg <= 1'b0;
            case (state_reg)
                OCIOSO: begin
                    if (bus.iniciar_envio) begin
                        shift_reg   <= bus.dado_entrada;
                        parity_reg  <= (PARITY == PARIDADE_IMPAR) ? ~(^bus.dado_entrada)
                                                                  :  (^bus.dado_entrada);
                        bit_idx_reg <= 3'd0;
                        tx_reg      <= 1'b0;
                        ocupado_reg <= 1'b1;
                        state_reg   <= INICIO;
                    end
                end
                INICIO: begin
                    if (bit_tick) begin
                        tx_reg    <= shift_reg[0];
                        state_reg <= DADOS;
                    end
                end
                DADOS: begin
                    if (bit_tick) begin
                        if (bit_idx_reg == 3'd7) begin
                            bit_idx_reg <= 3'd0;
                            if (PARITY != PARIDADE_NENHUMA) begin
                                tx_reg    <= parity_reg;
                                state_reg <= PARIDADE;
                            end else begin
                                tx_reg       <= 1'b1;
                                stop_cnt_reg <= 1'b0;
                                state_reg    <= PARADA;
                            end
                        end else begin
                            // Next bit is shift_reg[1] before the shift lands.
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                            tx_reg      <= shift_reg[1];
                        end
                    end
                end
                PARIDADE: begin
                    if (bit_tick) begin
                        tx_reg       <= 1'b1;
                        stop_cnt_reg <= 1'b0;
                        state_reg    <= PARADA;
                    end
                end
                PARADA: begin
                    if (bit_tick) begin
                        if (stop_cnt_reg == 1'(STOP_BITS - 1)) begin
                            ocupado_reg <= 1'b0;
                            enviado_reg <= 1'b1;
                            state_reg   <= OCIOSO;
                        end else begin
                            stop_cnt_reg <= stop_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    tx_reg      <= 1'b1;
                    ocupado_reg <= 1'b0;
                    state_reg   <= OCIOSO;
                end
            endcase
        end
    end

    assign bus.tx           = tx_reg;
    assign bus.uart_ocupado = ocupado_reg;
    assign bus.byte_enviado = enviado_reg;

endmodule
